keypad_entry_scanner: RTL and testbench

Parametrised matrix-keypad scanner with debounce and a multi-digit entry buffer for the safe-box datapath. It drives the column lines, decodes and debounces one key at a time, and emits a one-cycle key event. Keys are collected into an N-digit buffer with clear and enter command keys. A completed entry is presented to the password comparator over a valid/ack handshake.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_entry_buffer.sv | 71 +++++++
 rtl/keypad_entry_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_entry_scanner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad scanner and its entry buffer.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } scan_state_e;

  localparam int ENT_CODE_DEF  = 15;
  localparam int CLR_CODE_DEF  = 14;
  localparam int BKSP_CODE_DEF = 13;

  // Index width that stays >= 1 even for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_w(input int rows, input int cols);
    return idx_w(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_entry_buffer.sv
// N-digit entry buffer with clear/enter commands and valid/ack handshake.
// Backspace handling is compiled in with KEYPAD_BACKSPACE_EN.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int KW        = 4,
  parameter int CW        = 3,
  parameter int ENT_CODE  = ENT_CODE_DEF,
  parameter int CLR_CODE  = CLR_CODE_DEF,
  parameter int BKSP_CODE = BKSP_CODE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [KW-1:0]          key_code,
  input  logic                   entry_ack,
  output logic [N_DIGITS*KW-1:0] digits,
  output logic [CW-1:0]          count,
  output logic                   entry_valid
);

`ifdef KEYPAD_BACKSPACE_EN
  localparam bit BKSP_EN = 1'b1;
`else
  localparam bit BKSP_EN = 1'b0;
`endif

  localparam logic [KW-1:0] ENT_K  = KW'(ENT_CODE);
  localparam logic [KW-1:0] CLR_K  = KW'(CLR_CODE);
  localparam logic [KW-1:0] BKSP_K = KW'(BKSP_CODE);

  logic [N_DIGITS-1:0][KW-1:0] digits_q;
  logic [CW-1:0]               count_q;
  logic                        ev_q;

  // Ack takes priority over a coincident key; a frozen entry drops keys.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      count_q  <= '0;
      ev_q     <= 1'b0;
    end else if (entry_ack && ev_q) begin
      digits_q <= '0;
      count_q  <= '0;
      ev_q     <= 1'b0;
    end else if (key_valid && !ev_q) begin
      if (key_code == CLR_K) begin
        digits_q <= '0;
        count_q  <= '0;
      end else if (key_code == ENT_K) begin
        ev_q <= 1'b1;
      end else if (BKSP_EN && key_code == BKSP_K) begin
        if (count_q != '0) begin
          for (int i = 0; i < N_DIGITS; i++)
            if (count_q == CW'(i + 1)) digits_q[i] <= '0;
          count_q <= count_q - 1'b1;
        end
      end else if (count_q < CW'(N_DIGITS)) begin
        for (int i = 0; i < N_DIGITS; i++)
          if (count_q == CW'(i)) digits_q[i] <= key_code;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign digits      = digits_q;
  assign count       = count_q;
  assign entry_valid = ev_q;

endmodule

// File: rtl/keypad_entry_scanner.sv
// Matrix keypad scanner: tick generator, column-scan/debounce FSM, and entry buffer.
// Optional backspace command key enabled by KEYPAD_BACKSPACE_EN.
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 250000,
  parameter int DEB_TICKS = 4,
  parameter int ENT_CODE  = ENT_CODE_DEF,
  parameter int CLR_CODE  = CLR_CODE_DEF,
  parameter int BKSP_CODE = BKSP_CODE_DEF,
  localparam int KW = key_w(ROWS, COLS),
  localparam int CW = $clog2(N_DIGITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS-1:0]        row,
  output logic [COLS-1:0]        col,
  output logic                   key_valid,
  output logic [KW-1:0]          key_code,
  output logic [N_DIGITS*KW-1:0] digits,
  output logic [CW-1:0]          count,
  output logic                   entry_valid,
  input  logic                   entry_ack
);

  localparam int RW  = idx_w(ROWS);
  localparam int CIW = idx_w(COLS);
  localparam int TW  = idx_w(CLK_DIV);
  localparam int DW  = $clog2(DEB_TICKS + 1);

  logic [ROWS-1:0] row_m_q, row_s_q;
  logic [TW-1:0]   tcnt_q;
  logic            tick;
  scan_state_e     state_q;
  logic [COLS-1:0] col_q;
  logic [CIW-1:0]  col_idx_q;
  logic [RW-1:0]   row_idx_q, low_row;
  logic [DW-1:0]   deb_q;
  logic            kv_q;
  logic [KW-1:0]   kc_q;
  logic            any_low;

  function automatic logic [COLS-1:0] col_sel(input logic [CIW-1:0] i);
    return ~(COLS'(1) << i);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m_q <= '1;
      row_s_q <= '1;
    end else begin
      row_m_q <= row;
      row_s_q <= row_m_q;
    end
  end

  assign tick = (tcnt_q == TW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + 1'b1;
  end

  assign any_low = ~&row_s_q;

  // Lowest-index low row wins when several rows read low.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (!row_s_q[i]) low_row = RW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      col_idx_q <= '0;
      row_idx_q <= '0;
      deb_q     <= '0;
      kv_q      <= 1'b0;
      kc_q      <= '0;
    end else begin
      kv_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            col_q <= '0;
            if (any_low) begin
              state_q   <= S_SCAN;
              col_idx_q <= '0;
              col_q     <= col_sel('0);
            end
          end
          S_SCAN: begin
            if (any_low) begin
              state_q   <= S_DEBOUNCE;
              row_idx_q <= low_row;
              deb_q     <= DW'(1);
            end else if (col_idx_q == CIW'(COLS - 1)) begin
              state_q <= S_IDLE;
              col_q   <= '0;
            end else begin
              col_idx_q <= col_idx_q + 1'b1;
              col_q     <= col_sel(col_idx_q + 1'b1);
            end
          end
          S_DEBOUNCE: begin
            if (!row_s_q[row_idx_q]) begin
              deb_q <= deb_q + 1'b1;
              if (int'(deb_q) + 1 >= DEB_TICKS) begin
                state_q <= S_HELD;
                kv_q    <= 1'b1;
                kc_q    <= KW'(int'(row_idx_q) * COLS + int'(col_idx_q));
              end
            end else begin
              state_q <= S_IDLE;
              col_q   <= '0;
            end
          end
          S_HELD: begin
            if (!any_low) begin
              state_q <= S_RELEASE;
              deb_q   <= DW'(1);
            end
          end
          S_RELEASE: begin
            if (any_low) begin
              state_q <= S_HELD;
            end else begin
              deb_q <= deb_q + 1'b1;
              if (int'(deb_q) + 1 >= DEB_TICKS) begin
                state_q <= S_IDLE;
                col_q   <= '0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            col_q   <= '0;
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_valid = kv_q;
  assign key_code  = kc_q;

  keypad_entry_buffer #(
    .N_DIGITS (N_DIGITS),
    .KW       (KW),
    .CW       (CW),
    .ENT_CODE (ENT_CODE),
    .CLR_CODE (CLR_CODE),
    .BKSP_CODE(BKSP_CODE)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (kv_q),
    .key_code   (kc_q),
    .entry_ack  (entry_ack),
    .digits     (digits),
    .count      (count),
    .entry_valid(entry_valid)
  );

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner with CLK_DIV=4, DEB_TICKS=2.
module tb_keypad_entry_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        entry_valid, entry_ack;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;

  logic pressed;
  int   key_r, key_c;

  always #5 clk = ~clk;

  keypad_entry_scanner #(
    .ROWS(4), .COLS(4), .N_DIGITS(4), .CLK_DIV(4), .DEB_TICKS(2),
    .ENT_CODE(15), .CLR_CODE(14), .BKSP_CODE(13)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code),
    .digits(digits), .count(count),
    .entry_valid(entry_valid), .entry_ack(entry_ack)
  );

  // Keypad model: a pressed switch pulls its row low when its column is driven low.
  always_comb begin
    row = '1;
    if (pressed && !col[key_c]) row[key_r] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) ev_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * 4) @(posedge clk);
  endtask

  task automatic type_key(input int code);
    int e0;
    e0 = ev_cnt;
    @(negedge clk);
    key_r = code / 4;
    key_c = code % 4;
    pressed = 1'b1;
    ticks(12);
    @(negedge clk);
    pressed = 1'b0;
    ticks(8);
    @(negedge clk);
    chk($sformatf("ev_%0d", code), ev_cnt - e0, 1);
  endtask

  initial begin
    int e0, n;
    rst = 1'b1; pressed = 1'b0; key_r = 0; key_c = 0; entry_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", col, 4'b0000);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_kc", key_code, 4'd0);
    chk("rst_dig", digits, 16'h0);
    chk("rst_cnt", count, 3'd0);
    chk("rst_ev", entry_valid, 1'b0);
    @(negedge clk) rst = 1'b0;
    ticks(2);

    // 1: single press, long hold, no repeat
    type_key(6);
    chk("t1_code", key_code, 4'd6);
    chk("t1_cnt", count, 3'd1);
    chk("t1_d0", digits[3:0], 4'd6);

    // 2: full entry, frozen buffer, ack
    type_key(14);
    type_key(3); type_key(7); type_key(0); type_key(9); type_key(15);
    chk("t2_ev", entry_valid, 1'b1);
    chk("t2_dig", digits, 16'h9073);
    chk("t2_cnt", count, 3'd4);
    type_key(5);
    chk("t2_frz_dig", digits, 16'h9073);
    chk("t2_frz_cnt", count, 3'd4);
    @(negedge clk) entry_ack = 1'b1;
    @(posedge clk); #1;
    chk("t2_ack_ev", entry_valid, 1'b0);
    chk("t2_ack_dig", digits, 16'h0);
    chk("t2_ack_cnt", count, 3'd0);
    @(negedge clk) entry_ack = 1'b0;
    type_key(1);
    @(negedge clk) entry_ack = 1'b1;
    @(negedge clk) entry_ack = 1'b0;
    chk("t2_noack_cnt", count, 3'd1);
    chk("t2_noack_dig", digits, 16'h0001);

    // 3: saturation then clear
    type_key(14);
    type_key(1); type_key(2); type_key(3); type_key(4); type_key(5);
    chk("t3_cnt", count, 3'd4);
    chk("t3_dig", digits, 16'h4321);
    type_key(14);
    chk("t3_clr_cnt", count, 3'd0);
    chk("t3_clr_dig", digits, 16'h0);

    // 4: one-tick bounce
    e0 = ev_cnt;
    @(negedge clk);
    key_r = 2; key_c = 0; pressed = 1'b1;
    ticks(1);
    @(negedge clk) pressed = 1'b0;
    ticks(8);
    @(negedge clk);
    chk("t4_ev", ev_cnt - e0, 0);
    chk("t4_idle_col", col, 4'b0000);

    // 5: reset during debounce, then during a pending entry
    @(negedge clk);
    key_r = 1; key_c = 1; pressed = 1'b1;
    n = 0;
    while (dut.state_q != keypad_pkg::S_DEBOUNCE && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("t5_deb_seen", 32'(n < 200), 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_col", col, 4'b0000);
    chk("t5_kv", key_valid, 1'b0);
    chk("t5_kc", key_code, 4'd0);
    @(negedge clk) rst = 1'b0;
    e0 = ev_cnt;
    ticks(12);
    @(negedge clk);
    chk("t5_fresh_ev", ev_cnt - e0, 1);
    chk("t5_fresh_kc", key_code, 4'd5);
    pressed = 1'b0;
    ticks(8);
    type_key(15);
    chk("t5_ev_pend", entry_valid, 1'b1);
    chk("t5_dig_pend", digits, 16'h0005);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_ev", entry_valid, 1'b0);
    chk("t5_rst_cnt", count, 3'd0);
    chk("t5_rst_dig", digits, 16'h0);
    chk("t5_rst_col", col, 4'b0000);
    @(negedge clk) rst = 1'b0;
    ticks(2);

    // 6: backspace key
    type_key(1); type_key(2); type_key(13);
`ifdef KEYPAD_BACKSPACE_EN
    chk("t6_cnt", count, 3'd1);
    chk("t6_dig", digits, 16'h0001);
`else
    chk("t6_cnt", count, 3'd3);
    chk("t6_d2", digits[11:8], 4'd13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
